mux_rr_reg: RTL

- Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake.
- Two selection modes:
  - fixed select: the channel is chosen by S.
  - round-robin: the block arbitrates among valid channels.
- Output is a single registered stage with a valid/ready handshake.
- Sits between producer channels and one shared downstream consumer (bus, ALU port, UART TX); replaces hand-instantiated 4:1 muxes where flow control is needed.

---
 rtl/mux_rr_reg.sv | 68 ++++++
 1 files changed

// File: rtl/mux_rr_reg.sv
// mux_rr_reg: N-channel registered mux with fixed-select or round-robin arbitration and valid/ready handshakes
module mux_rr_reg #(
  parameter int W = 8,
  parameter int N = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            RR_EN,
  input  logic [SELW-1:0] S,
  input  logic [N*W-1:0]  D_IN,
  input  logic [N-1:0]    V_IN,
  output logic [N-1:0]    RDY_IN,
  output logic [W-1:0]    F,
  output logic            F_V,
  input  logic            F_RDY,
  output logic [SELW-1:0] GNT
);
  localparam logic [SELW:0] NL = N[SELW:0];
  logic [SELW-1:0] last, c, c_rr;
  logic found, cand_ok, load_ok, v_sel, xfer;
  logic [W-1:0] d_sel;
  assign load_ok = !F_V || F_RDY;
  always_comb begin
    found = 1'b0;
    c_rr = '0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = int'(last) + k;
      j = (j >= N) ? j - N : j;
      if (!found && V_IN[j]) begin
        found = 1'b1;
        c_rr = SELW'(j);
      end
    end
  end
  assign c = RR_EN ? c_rr : S;
  assign cand_ok = RR_EN ? found : ({1'b0, S} < NL);
  always_comb begin
    d_sel = '0;
    v_sel = 1'b0;
    RDY_IN = '0;
    for (int i = 0; i < N; i++) begin
      if (SELW'(i) == c) begin
        d_sel = D_IN[i*W +: W];
        v_sel = V_IN[i];
        RDY_IN[i] = cand_ok && load_ok && RST_N;
      end
    end
  end
  assign xfer = cand_ok && load_ok && v_sel && RST_N;
  // a simultaneous drain and load keeps F_V high, giving one word per cycle
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      F <= '0;
      F_V <= 1'b0;
      GNT <= '0;
      last <= SELW'(N - 1);
    end else if (xfer) begin
      F <= d_sel;
      F_V <= 1'b1;
      GNT <= c;
      last <= c;
    end else if (F_RDY) begin
      F_V <= 1'b0;
    end
  end
endmodule
